// File: rtl/sbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sbus_pkg
//  Description : Shared types and constants for the simple-bus arbiter.
//                Holds the controller state encoding, the default
//                parameter values and an index-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sbus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } sbus_state_t;

    localparam int c_DEF_N_MST   = 4;
    localparam int c_DEF_ADDR_W  = 8;
    localparam int c_DEF_DATA_W  = 32;
    localparam int c_DEF_TIMEOUT = 16;
    localparam int c_ERR_CNT_W   = 16;
    // TIMEOUT is limited to 255, so 8 bits always hold the cycle count
    localparam int c_TCNT_W      = 8;

    // Width of a master index; never less than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sbus_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sbus_rr_arbiter
//  Description : Combinational round-robin arbiter. The search for a
//                requester starts one position after last_grant and wraps.
//  Ports       : req        - per-master request vector
//                last_grant - index of the most recently granted master
//                grant      - one-hot grant (all zero when no request)
//                grant_idx  - binary index of the granted master
//                any        - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module sbus_rr_arbiter
    import sbus_pkg::*;
#(
    parameter int N_MST = c_DEF_N_MST,
    parameter int IDX_W = idx_w(N_MST)
) (
    input  logic [N_MST-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_MST-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    int w_pos;

    // Walk candidates from lowest to highest priority; a later hit overwrites
    // an earlier one, so the highest-priority requester is what remains.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_pos     = 0;
        for (int off = N_MST; off >= 1; off--) begin
            w_pos = (int'(last_grant) + off) % N_MST;
            if (req[w_pos[IDX_W-1:0]]) begin
                grant                     = '0;
                grant[w_pos[IDX_W-1:0]]   = 1'b1;
                grant_idx                 = w_pos[IDX_W-1:0];
            end
        end
    end

    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/sbus_arb.sv
`default_nettype none
// ============================================================================
//  Module      : sbus_arb
//  Description : Round-robin arbiter from N_MST masters onto one target bus.
//                IDLE grants one requester and latches its command, ACCESS
//                drives the target until s_ready or timeout, RESP returns a
//                one-cycle m_ready pulse (with m_err on timeout).
//  Ports       : clk, rst (sync, active-high)
//                m_wr/m_rd/m_addr/m_wdata - per-master requests and operands
//                m_rdata/m_ready/m_err    - shared read data, per-master
//                                           completion and timeout flag
//                s_wr/s_rd/s_addr/s_wdata - target command
//                s_rdata/s_ready          - target response
//                err_cnt                  - saturating timeout counter
//  Revision    : 1.0 - initial release
// ============================================================================
module sbus_arb
    import sbus_pkg::*;
#(
    parameter int N_MST   = c_DEF_N_MST,
    parameter int ADDR_W  = c_DEF_ADDR_W,
    parameter int DATA_W  = c_DEF_DATA_W,
    parameter int TIMEOUT = c_DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_MST-1:0]          m_wr,
    input  logic [N_MST-1:0]          m_rd,
    input  logic [N_MST*ADDR_W-1:0]   m_addr,
    input  logic [N_MST*DATA_W-1:0]   m_wdata,
    output logic [DATA_W-1:0]         m_rdata,
    output logic [N_MST-1:0]          m_ready,
    output logic [N_MST-1:0]          m_err,
    output logic                      s_wr,
    output logic                      s_rd,
    output logic [ADDR_W-1:0]         s_addr,
    output logic [DATA_W-1:0]         s_wdata,
    input  logic [DATA_W-1:0]         s_rdata,
    input  logic                      s_ready,
    output logic [c_ERR_CNT_W-1:0]    err_cnt
);

    localparam int                    c_IW      = idx_w(N_MST);
    localparam logic [c_TCNT_W-1:0]   c_TO_LAST = c_TCNT_W'(TIMEOUT - 1);

    sbus_state_t            r_state;
    sbus_state_t            w_next;
    logic [c_IW-1:0]        r_last;
    logic                   r_dir_wr;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic [c_TCNT_W-1:0]    r_tcnt;
    logic [c_ERR_CNT_W-1:0] r_err_cnt;
    logic                   r_s_wr;
    logic                   r_s_rd;
    logic [DATA_W-1:0]      r_m_rdata;
    logic [N_MST-1:0]       r_m_ready;
    logic [N_MST-1:0]       r_m_err;

    logic [N_MST-1:0]       w_req;
    logic [N_MST-1:0]       w_gnt;
    logic [c_IW-1:0]        w_gnt_idx;
    logic                   w_any;
    logic                   w_sel_wr;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_wdata;
    logic                   w_grant_now;
    logic                   w_timeout;
    logic                   w_dir_nxt;
    logic                   w_s_wr_nxt;
    logic                   w_s_rd_nxt;
    logic [N_MST-1:0]       w_onehot;
    logic [N_MST-1:0]       w_m_ready_nxt;
    logic [N_MST-1:0]       w_m_err_nxt;
    logic [DATA_W-1:0]      w_m_rdata_nxt;
    logic [c_ERR_CNT_W-1:0] w_err_cnt_nxt;

    assign w_req = m_wr | m_rd;

    sbus_rr_arbiter #(
        .N_MST (N_MST),
        .IDX_W (c_IW)
    ) u_rr (
        .req        (w_req),
        .last_grant (r_last),
        .grant      (w_gnt),
        .grant_idx  (w_gnt_idx),
        .any        (w_any)
    );

    // Operand mux for the winning master; a write request dominates a read
    always_comb begin
        w_sel_wr    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (w_gnt[i]) begin
                w_sel_wr    = m_wr[i];
                w_sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = m_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; s_ready wins over an expiring timeout
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                if (s_ready) begin
                    w_next = RESP;
                end else if (r_tcnt == c_TO_LAST) begin
                    w_next    = RESP;
                    w_timeout = 1'b1;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs. r_last already
    // holds the current grant once ACCESS is entered.
    always_comb begin
        w_grant_now   = (r_state == IDLE) && w_any;
        w_dir_nxt     = w_grant_now ? w_sel_wr : r_dir_wr;
        w_s_wr_nxt    = (w_next == ACCESS) &&  w_dir_nxt;
        w_s_rd_nxt    = (w_next == ACCESS) && !w_dir_nxt;
        w_onehot      = N_MST'(1) << r_last;
        w_m_ready_nxt = (w_next == RESP) ? w_onehot : '0;
        w_m_err_nxt   = w_timeout ? w_onehot : '0;
        w_m_rdata_nxt = r_m_rdata;
        if ((r_state == ACCESS) && (w_next == RESP)) begin
            // Writes and timeouts return zero data
            w_m_rdata_nxt = (s_ready && !r_dir_wr) ? s_rdata : '0;
        end
        w_err_cnt_nxt = r_err_cnt;
        if (w_timeout && (r_err_cnt != '1)) begin
            w_err_cnt_nxt = r_err_cnt + 1'b1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last    <= c_IW'(N_MST - 1);
            r_dir_wr  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_tcnt    <= '0;
            r_err_cnt <= '0;
            r_s_wr    <= 1'b0;
            r_s_rd    <= 1'b0;
            r_m_rdata <= '0;
            r_m_ready <= '0;
            r_m_err   <= '0;
        end else begin
            if (w_grant_now) begin
                r_last   <= w_gnt_idx;
                r_dir_wr <= w_sel_wr;
                r_addr   <= w_sel_addr;
                r_wdata  <= w_sel_wdata;
                r_tcnt   <= '0;
            end else if (r_state == ACCESS) begin
                r_tcnt   <= r_tcnt + 1'b1;
            end
            r_err_cnt <= w_err_cnt_nxt;
            r_s_wr    <= w_s_wr_nxt;
            r_s_rd    <= w_s_rd_nxt;
            r_m_rdata <= w_m_rdata_nxt;
            r_m_ready <= w_m_ready_nxt;
            r_m_err   <= w_m_err_nxt;
        end
    end

    assign m_rdata = r_m_rdata;
    assign m_ready = r_m_ready;
    assign m_err   = r_m_err;
    assign s_wr    = r_s_wr;
    assign s_rd    = r_s_rd;
    assign s_addr  = r_addr;
    assign s_wdata = r_wdata;
    assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sbus_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sbus_arb
//  Description : Self-checking bench for sbus_arb. Each transaction's
//                winner, bus command, latency and response are predicted
//                from the arbitration rules and compared every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sbus_arb;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      m_wr, m_rd;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_wdata;
    logic [DW-1:0]     m_rdata;
    logic [N-1:0]      m_ready, m_err;
    logic              s_wr, s_rd;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata, s_rdata;
    logic              s_ready;
    logic [15:0]       err_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int last_g;     // model: last granted master
    int errs;       // model: timeout count

    always #5 clk = ~clk;

    sbus_arb #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .m_wr    (m_wr),
        .m_rd    (m_rd),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .m_err   (m_err),
        .s_wr    (s_wr),
        .s_rd    (s_rd),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ready (s_ready),
        .err_cnt (err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // First requester found scanning upward from last_g+1, wrapping
    function automatic int pick(input logic [N-1:0] req);
        logic [N-1:0] t;
        for (int off = 1; off <= N; off++) begin
            t = req >> ((last_g + off) % N);
            if (t[0]) return (last_g + off) % N;
        end
        return -1;
    endfunction

    // One full transaction from IDLE: grant, ACCESS, RESP, back to IDLE.
    // ready_at = ACCESS cycle on which s_ready is given (0 = never).
    task automatic do_txn(input logic [N-1:0] wr, input logic [N-1:0] rd,
                          input logic [N*AW-1:0] addr, input logic [N*DW-1:0] wdata,
                          input int ready_at, input logic [DW-1:0] rdata,
                          output int win);
        logic [N-1:0]  t;
        logic          is_wr, tmo;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, er;
        int            ncyc;
        win     = pick(wr | rd);
        m_wr    = wr;
        m_rd    = rd;
        m_addr  = addr;
        m_wdata = wdata;
        s_ready = 1'b0;
        if (win < 0) begin
            step();
            chk("idle_no_req", {s_wr, s_rd}, 2'b00);
            return;
        end
        t     = wr >> win;
        is_wr = t[0];
        ea    = addr[win*AW +: AW];
        ed    = wdata[win*DW +: DW];
        tmo   = (ready_at < 1) || (ready_at > TO);
        ncyc  = tmo ? TO : ready_at;
        step();
        for (int c = 1; c <= ncyc; c++) begin
            chk("acc_s_wr",    s_wr, is_wr);
            chk("acc_s_rd",    s_rd, !is_wr);
            chk("acc_s_addr",  s_addr, ea);
            chk("acc_s_wdata", s_wdata, ed);
            chk("acc_m_ready", m_ready, 0);
            s_ready = (c == ready_at);
            s_rdata = s_ready ? rdata : $urandom;
            step();
        end
        er = (tmo || is_wr) ? '0 : rdata;
        if (tmo && errs < 65535) errs++;
        chk("resp_m_ready", m_ready, N'(1) << win);
        chk("resp_m_err",   m_err, tmo ? (N'(1) << win) : '0);
        chk("resp_m_rdata", m_rdata, er);
        chk("resp_s_cmd",   {s_wr, s_rd}, 2'b00);
        chk("resp_err_cnt", err_cnt, errs);
        s_ready = 1'b0;
        m_wr    = m_wr & ~(N'(1) << win);
        m_rd    = m_rd & ~(N'(1) << win);
        last_g  = win;
        step();
        chk("idle_m_ready", m_ready, 0);
        chk("idle_m_err",   m_err, 0);
        chk("idle_rdata_hold", m_rdata, er);
    endtask

    initial begin
        int            w;
        logic [N-1:0]  rwr, rrd;
        logic [N*AW-1:0] raddr;
        logic [N*DW-1:0] rwd;
        int            r, ra;

        rst = 1'b1; m_wr = '0; m_rd = '0; m_addr = '0; m_wdata = '0;
        s_rdata = '0; s_ready = 1'b0;
        last_g = N - 1; errs = 0;
        step(); step();
        chk("rst_s_cmd",   {s_wr, s_rd}, 2'b00);
        chk("rst_m_ready", m_ready, 0);
        chk("rst_m_err",   m_err, 0);
        chk("rst_m_rdata", m_rdata, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_s_addr",  s_addr, 0);
        rst = 1'b0;

        // All masters requesting continuously: expect 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            do_txn(4'hF, 4'h0, {8'h33, 8'h22, 8'h11, 8'h00},
                   {32'h3333, 32'h2222, 32'h1111, 32'h0000}, 1, '0, w);
        end
        m_wr = '0; m_rd = '0;

        // Single zero-wait write from master 0
        do_txn(4'b0001, 4'b0000, {24'h0, 8'h10}, {96'h0, 32'hA5A5_0001}, 1, '0, w);
        step();
        chk("no_regrant", {s_wr, s_rd}, 2'b00);

        // Read with three wait states from master 2
        do_txn(4'b0000, 4'b0100, {8'h0, 8'h24, 16'h0}, '0, 4, 32'hCAFE_F00D, w);

        // Write and read both high on master 3: treated as a write
        do_txn(4'b1000, 4'b1000, {8'h7E, 24'h0}, {32'h1234_5678, 96'h0}, 2, 32'hDEAD_BEEF, w);

        // Reset in the middle of a read access
        m_rd = 4'b0100; m_addr = {8'h0, 8'h55, 16'h0};
        step();
        chk("pre_rst_s_rd", s_rd, 1'b1);
        step();
        chk("pre_rst_s_rd2", s_rd, 1'b1);
        rst = 1'b1; m_rd = '0;
        step();
        rst = 1'b0;
        last_g = N - 1;
        chk("mid_rst_s_rd",    s_rd, 1'b0);
        chk("mid_rst_m_ready", m_ready, 0);
        chk("mid_rst_err_cnt", err_cnt, errs);
        step();
        chk("mid_rst_no_resp", m_ready, 0);
        do_txn(4'hF, 4'h0, '0, '0, 1, '0, w);
        m_wr = '0; m_rd = '0;

        // Timeout, then s_ready exactly on the last allowed cycle
        do_txn(4'b0000, 4'b0010, {16'h0, 8'h99, 8'h0}, '0, 0, 32'hFFFF_FFFF, w);
        do_txn(4'b0000, 4'b0010, {16'h0, 8'h9A, 8'h0}, '0, TO, 32'h0BAD_CAFE, w);
        do_txn(4'b0000, 4'b0000, '0, '0, 1, '0, w);

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            rwr   = N'($urandom);
            rrd   = N'($urandom);
            if ((rwr | rrd) == '0) rrd = N'(1) << $urandom_range(0, N - 1);
            raddr = {$urandom};
            rwd   = {$urandom, $urandom, $urandom, $urandom};
            r     = $urandom_range(0, 9);
            ra    = (r == 0) ? 0 : (r == 1) ? TO : $urandom_range(1, 4);
            do_txn(rwr, rrd, raddr, rwd, ra, $urandom, w);
            m_wr = '0; m_rd = '0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
